// File: rtl/hex_display_arbiter.sv
// Round-robin time-slicing arbiter sharing a four-digit BCD display between requesters A and B.
// Grants last at least DWELL cycles; all outputs come straight from registers.
module hex_display_arbiter #(
    parameter int DWELL = 50_000_000,
    parameter int CNT_W = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        REQ_A,
    input  logic [15:0] DATA_A,
    input  logic        REQ_B,
    input  logic [15:0] DATA_B,
    output logic [3:0]  BCD_0,
    output logic [3:0]  BCD_1,
    output logic [3:0]  BCD_2,
    output logic [3:0]  BCD_3,
    output logic        GNT_A,
    output logic        GNT_B,
    output logic        VALID
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW_A = 2'd1,
        SHOW_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic             last_b_q, last_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             frozen_q, frozen_d;
    logic             enter_a, enter_b;
    logic             dwell_done;

    assign dwell_done = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            cnt_q    <= '0;
            bcd_q    <= '0;
            frozen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            frozen_q <= frozen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        frozen_d = frozen_q;
        enter_a  = 1'b0;
        enter_b  = 1'b0;

        case (state_q)
            IDLE: begin
                if (REQ_A && REQ_B) begin
                    enter_a = last_b_q;
                    enter_b = !last_b_q;
                end else begin
                    enter_a = REQ_A;
                    enter_b = REQ_B;
                end
            end
            SHOW_A: begin
                if (dwell_done && REQ_B) begin
                    enter_b = 1'b1;
                end else if (dwell_done && !REQ_A) begin
                    state_d = IDLE;
                end else begin
                    if (!dwell_done) cnt_d = cnt_q + CNT_W'(1);
                    // Once the owner drops its request the display freezes for the rest of the grant.
                    if (!REQ_A)         frozen_d = 1'b1;
                    else if (!frozen_q) bcd_d    = DATA_A;
                end
            end
            SHOW_B: begin
                if (dwell_done && REQ_A) begin
                    enter_a = 1'b1;
                end else if (dwell_done && !REQ_B) begin
                    state_d = IDLE;
                end else begin
                    if (!dwell_done) cnt_d = cnt_q + CNT_W'(1);
                    if (!REQ_B)         frozen_d = 1'b1;
                    else if (!frozen_q) bcd_d    = DATA_B;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_a) begin
            state_d  = SHOW_A;
            last_b_d = 1'b0;
            cnt_d    = '0;
            bcd_d    = DATA_A;
            frozen_d = 1'b0;
        end else if (enter_b) begin
            state_d  = SHOW_B;
            last_b_d = 1'b1;
            cnt_d    = '0;
            bcd_d    = DATA_B;
            frozen_d = 1'b0;
        end
    end

    assign GNT_A = (state_q == SHOW_A);
    assign GNT_B = (state_q == SHOW_B);
    assign VALID = (state_q != IDLE);
    assign BCD_0 = bcd_q[3:0];
    assign BCD_1 = bcd_q[7:4];
    assign BCD_2 = bcd_q[11:8];
    assign BCD_3 = bcd_q[15:12];

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Time-slicing arbiter that shares the four-digit 7-segment display (four BCD digit inputs, each feeding a hex-to-7-segment decoder) between two requesters, A and B. Each requester presents a 16-bit packed BCD value and a request. The block grants the display round-robin with a guaranteed minimum dwell time. It drives registered BCD digits to the decoders, plus grant and valid indications.

## Interface
- DWELL, 50_000_000, minimum grant length in clock cycles; must be ≥ 2.
- CNT_W, 26, dwell counter width; must satisfy 2^CNT_W ≥ DWELL.

Ports (clock and reset first):
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- REQ_A  input  1  requester A wants the display.
- DATA_A  input  16  requester A digits; [3:0]=LSD … [15:12]=MSD.
- REQ_B  input  1  requester B wants the display.
- DATA_B  input  16  requester B digits, same packing.
- BCD_0, BCD_1, BCD_2, BCD_3  output  4 each  digits LSD to MSD, to the decoders.
- GNT_A  output  1  A currently owns the display.
- GNT_B  output  1  B currently owns the display.
- VALID  output  1  a grant is active (GNT_A | GNT_B).

## Operation
- States: IDLE, SHOW_A, SHOW_B. GNT_A=1 only in SHOW_A; GNT_B=1 only in SHOW_B; never both.
- Pointer LAST records the most recently granted requester. Reset value is B, so A wins the first tie.
- IDLE transitions:
  - Only REQ_A → SHOW_A.
  - Only REQ_B → SHOW_B.
  - Both → the requester that is not LAST.
  - Neither → stay in IDLE.
- On every grant entry: dwell counter ← 0; LAST ← new owner; BCD_3..0 ← the new owner's DATA on the same edge.
- While in SHOW_X:
  - Counter increments each cycle and saturates at DWELL-1.
  - "Dwell done" means counter == DWELL-1.
  - If REQ_X=1, BCD_3..0 ← DATA_X every cycle (live tracking, registered).
  - If REQ_X=0, BCD holds its last value. Holding continues until the grant ends, even if REQ_X reasserts later within the same dwell.
- Exits from SHOW_X are evaluated only when dwell is done:
  - Other requester's REQ=1 → switch directly to SHOW_other. This is a grant entry: counter cleared, data loaded; there is no IDLE cycle.
  - Else REQ_X=0 → IDLE.
  - Else stay in SHOW_X. Counter stays saturated, so a later request from the other side switches on the next edge.
- Before dwell is done, no exit happens regardless of requests.
- Digit values 10–15 pass through unmodified; the decoder displays them as hex.
- In IDLE, BCD outputs hold their last values and VALID=0.

## Timing
- Reset (asynchronous, immediate): state=IDLE, LAST=B, counter=0, GNT_A=GNT_B=VALID=0, BCD_0..3=4'h0.
- All outputs are registered; no combinational path from inputs to outputs.
- Request-to-grant latency from IDLE: 1 cycle. A REQ sampled high at edge n gives GNT high after edge n.
- Data latency: 1 cycle. DATA_X sampled at edge n appears on BCD after edge n.
- Minimum grant length: exactly DWELL cycles. Counter values 0..DWELL-1 are each seen once before an exit can occur.
- Switch A→B: GNT_A falls and GNT_B rises on the same edge. VALID stays high throughout.
- Both REQ rising in the same cycle from IDLE: the non-LAST requester is granted. After its dwell the other is granted. Under constant contention the owner alternates every DWELL cycles.
- Reset asserted mid-grant: all outputs go to reset values without waiting for a clock. After release, arbitration restarts from IDLE with A favoured.

## Test plan
Run with DWELL=4, CNT_W=2.
- Reset: rst_n=0 mid-SHOW_A, with no clock edge → GNT_A=0, VALID=0, BCD all 0 immediately. After release with REQ_A=1 → GNT_A=1 one cycle later.
- Single requester: REQ_A=1, DATA_A=16'h1234 → one cycle later GNT_A=1 and BCD_3..0=1,2,3,4. Change DATA_A to 16'h5678 → BCD=5,6,7,8 one cycle later. Drop REQ_A after dwell → IDLE, GNT_A=0, BCD stays 5678.
- Tie from reset: REQ_A=REQ_B=1, DATA_B=16'h9999 → A granted for exactly 4 cycles, then B for 4 cycles, alternating.
- Early release: REQ_A pulses for 1 cycle with DATA_A=16'h0042 → GNT_A high exactly 4 cycles, BCD frozen at 0042, then IDLE.
- Preempt attempt: during A's dwell, REQ_B rises at counter=1 → no switch until counter=3. GNT_B rises on the next edge with BCD=DATA_B, and GNT_A/GNT_B are never both high.
- Saturated hold: REQ_A held for 10 cycles with REQ_B low, then REQ_B=1 → switch to B on the first edge after REQ_B is sampled.
